// File: rtl/stage_if.sv
// Fetch stage: fetch PC plus a 2-entry in-order buffer, one instruction per cycle to decode.
// Fill latency 2 cycles with zero-wait memory; id_stall holds the head; issue stops when the buffer is full.
module stage_if #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXN_VECTOR = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        id_branch,
  input  logic [31:0] id_branch_dest,
  input  logic        exn,
  output logic [31:0] pc,
  output logic [31:0] nextpc,
  output logic [31:0] instr,
  output logic        bubble,
  output logic        stall
);

  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } slot_t;

  slot_t       slot [2];
  logic [1:0]  slot_alloc;
  logic [1:0]  slot_filled;
  logic        head;
  logic        tail;
  logic [31:0] fpc;
  logic [1:0]  outst;
  logic [1:0]  discard;

  logic        head_filled;
  logic        deq;
  logic        grant;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        rsp_take;
  logic        rsp_drop;
  logic        rsp_fill;
  logic        fill_idx;
  logic [2:0]  used;
  logic [1:0]  outst_nxt;

  always_comb begin
    head_filled = slot_filled[head];
    deq         = head_filled && !id_stall;
    // discards still occupy response bandwidth, so they count against the two-request window
    used        = 3'(slot_alloc[0]) + 3'(slot_alloc[1]) + 3'(discard);
    imem_req    = !rst && ((used < 3'd2) || deq);
    imem_addr   = fpc;
    grant       = imem_req && imem_gnt;
    redirect    = exn || id_branch;
    redirect_pc = exn ? (EXN_VECTOR & ALIGN) : (id_branch_dest & ALIGN);
    rsp_take    = imem_rvalid && (outst != 2'd0);
    rsp_drop    = rsp_take && (discard != 2'd0);
    fill_idx    = (slot_alloc[head] && !slot_filled[head]) ? head : ~head;
    rsp_fill    = rsp_take && (discard == 2'd0) && slot_alloc[fill_idx] && !slot_filled[fill_idx];
    outst_nxt   = outst - 2'(rsp_take) + 2'(grant);
  end

  always_comb begin
    bubble = !head_filled;
    stall  = !head_filled;
    pc     = slot_alloc[head] ? slot[head].pc : fpc;
    instr  = head_filled ? slot[head].instr : 32'h0;
    nextpc = pc + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc         <= RESET_PC & ALIGN;
      slot_alloc  <= 2'b00;
      slot_filled <= 2'b00;
      head        <= 1'b0;
      tail        <= 1'b0;
      outst       <= 2'd0;
      discard     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        slot[i] <= '0;
      end
    end else begin
      outst <= outst_nxt;
      if (redirect) begin
        // everything still in flight, including a grant taken this cycle, becomes a discard
        fpc         <= redirect_pc;
        slot_alloc  <= 2'b00;
        slot_filled <= 2'b00;
        head        <= 1'b0;
        tail        <= 1'b0;
        discard     <= outst_nxt;
      end else begin
        if (rsp_drop) begin
          discard <= discard - 2'd1;
        end
        if (rsp_fill) begin
          slot[fill_idx].instr  <= imem_rdata;
          slot_filled[fill_idx] <= 1'b1;
        end
        if (deq) begin
          slot_alloc[head]  <= 1'b0;
          slot_filled[head] <= 1'b0;
          head              <= ~head;
        end
        // placed after deq so a slot freed this cycle can be re-allocated
        if (grant) begin
          slot[tail].pc     <= fpc;
          slot_alloc[tail]  <= 1'b1;
          slot_filled[tail] <= 1'b0;
          tail              <= ~tail;
          fpc               <= fpc + 32'd4;
        end
      end
    end
  end

endmodule
